// File: rtl/prog_seq_pkg.sv
// Shared types and defaults for the program sequencer.
package prog_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        HALTED,
        DONE
    } state_t;

    localparam int unsigned CW_DEFAULT = 16;

endpackage

// File: rtl/init_edge_det.sv
// Registers the bench init request and flags its rising and falling edges.
module init_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    output logic rise,
    output logic fall
);

    logic init_q;

    // One-cycle history of init for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
        end else begin
            init_q <= init;
        end
    end

    assign rise = init & ~init_q;
    assign fall = ~init & init_q;

endmodule

// File: rtl/prog_sequencer.sv
// Program-state sequencer: selects the active program from init pulses, walks it through
// load/run/halt, strobes the core and measures how many cycles each program ran.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned NUM_PROGS = 3,
    parameter int unsigned WRAP      = 0,
    parameter int unsigned CW        = CW_DEFAULT,
    localparam int unsigned PW       = $clog2(NUM_PROGS + 1)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          init,
    input  logic          halt,
    output logic [PW-1:0] ProgState,
    output logic          core_reset,
    output logic          core_start,
    output logic          busy,
    output logic          all_done,
    output logic [CW-1:0] cycle_count
);

    localparam logic [PW-1:0] LAST    = PW'(NUM_PROGS);
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam bit            WRAP_EN = (WRAP != 0);

    state_t        state_q, state_d;
    logic [PW-1:0] prog_q, prog_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d;
    logic          rise, fall;
    logic          at_last;

    init_edge_det u_init_edge_det (
        .clk  (CLK),
        .rst_n(RST_n),
        .init (init),
        .rise (rise),
        .fall (fall)
    );

    // Without wrap, finishing or reloading the last program ends sequencing for good.
    assign at_last = (prog_q == LAST);

    // Next-state, program index and run-cycle counter.
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = LOAD;
            end
            LOAD: begin
                if (fall) begin
                    if (at_last && !WRAP_EN) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        start_d = 1'b1;
                        cnt_d   = '0;
                        prog_d  = at_last ? ONE : prog_q + ONE;
                    end
                end
            end
            RUN: begin
                // A new init request aborts the run even if halt arrives on the same edge.
                if (rise) begin
                    state_d = LOAD;
                end else if (halt) begin
                    state_d = HALTED;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALTED: begin
                if (at_last && !WRAP_EN) begin
                    state_d = DONE;
                end else if (rise) begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, program index, counter and start-strobe registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            prog_q  <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    assign ProgState   = prog_q;
    assign core_reset  = (state_q == LOAD);
    assign core_start  = start_q;
    assign busy        = (state_q == RUN);
    assign all_done    = (state_q == DONE);
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench: three sequencer instances (3 progs/no wrap, 2 progs/wrap,
// 3 progs/4-bit counter) checked every cycle against a behavioural model.
module tb_prog_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_v [3];
    logic halt_v [3];

    logic [1:0]  ps_a, ps_b, ps_c;
    logic        cr_a, cr_b, cr_c, cs_a, cs_b, cs_c;
    logic        bz_a, bz_b, bz_c, ad_a, ad_b, ad_c;
    logic [15:0] cc_a, cc_b;
    logic [3:0]  cc_c;

    int n_checks = 0;
    int n_err = 0;
    int starts_a = 0;

    always #5 clk = ~clk;

    prog_sequencer #(.NUM_PROGS(3), .WRAP(0), .CW(16)) dut_a (
        .CLK(clk), .RST_n(rst_n), .init(init_v[0]), .halt(halt_v[0]), .ProgState(ps_a),
        .core_reset(cr_a), .core_start(cs_a), .busy(bz_a), .all_done(ad_a), .cycle_count(cc_a)
    );
    prog_sequencer #(.NUM_PROGS(2), .WRAP(1), .CW(16)) dut_b (
        .CLK(clk), .RST_n(rst_n), .init(init_v[1]), .halt(halt_v[1]), .ProgState(ps_b),
        .core_reset(cr_b), .core_start(cs_b), .busy(bz_b), .all_done(ad_b), .cycle_count(cc_b)
    );
    prog_sequencer #(.NUM_PROGS(3), .WRAP(0), .CW(4)) dut_c (
        .CLK(clk), .RST_n(rst_n), .init(init_v[2]), .halt(halt_v[2]), .ProgState(ps_c),
        .core_reset(cr_c), .core_start(cs_c), .busy(bz_c), .all_done(ad_c), .cycle_count(cc_c)
    );

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HALT = 3, P_DONE = 4;

    typedef struct packed {
        int ph;
        int prog;
        int cnt;
        bit start;
        bit init_prev;
    } mdl_t;

    mdl_t m [3];

    function automatic mdl_t m_next(mdl_t s, bit in, bit h, int np, bit wrap, int cmax);
        mdl_t n;
        bit r, f;
        n = s;
        r = in && !s.init_prev;
        f = !in && s.init_prev;
        n.init_prev = in;
        n.start = 1'b0;
        case (s.ph)
            P_IDLE: if (r) n.ph = P_LOAD;
            P_LOAD: begin
                if (f) begin
                    if (s.prog == np && !wrap) begin
                        n.ph = P_DONE;
                    end else begin
                        n.ph = P_RUN;
                        n.start = 1'b1;
                        n.cnt = 0;
                        n.prog = (s.prog % np) + 1;
                    end
                end
            end
            P_RUN: begin
                if (r) n.ph = P_LOAD;
                else if (h) n.ph = P_HALT;
                else n.cnt = (s.cnt < cmax) ? s.cnt + 1 : cmax;
            end
            P_HALT: begin
                if (s.prog == np && !wrap) n.ph = P_DONE;
                else if (r) n.ph = P_LOAD;
            end
            default: n.ph = s.ph;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m[i] <= '0;
        end else begin
            m[0] <= m_next(m[0], init_v[0], halt_v[0], 3, 1'b0, 65535);
            m[1] <= m_next(m[1], init_v[1], halt_v[1], 2, 1'b1, 65535);
            m[2] <= m_next(m[2], init_v[2], halt_v[2], 3, 1'b0, 15);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int k, input int ps, input int cr, input int cs, input int bz,
                           input int ad, input int cc);
        chk($sformatf("dut%0d ProgState", k), ps, m[k].prog);
        chk($sformatf("dut%0d core_reset", k), cr, int'(m[k].ph == P_LOAD));
        chk($sformatf("dut%0d core_start", k), cs, int'(m[k].start));
        chk($sformatf("dut%0d busy", k), bz, int'(m[k].ph == P_RUN));
        chk($sformatf("dut%0d all_done", k), ad, int'(m[k].ph == P_DONE));
        chk($sformatf("dut%0d cycle_count", k), cc, m[k].cnt);
    endtask

    // Compare all instances against the model midway between rising edges.
    always @(negedge clk) begin
        if (rst_n) begin
            cmp_dut(0, int'(ps_a), int'(cr_a), int'(cs_a), int'(bz_a), int'(ad_a), int'(cc_a));
            cmp_dut(1, int'(ps_b), int'(cr_b), int'(cs_b), int'(bz_b), int'(ad_b), int'(cc_b));
            cmp_dut(2, int'(ps_c), int'(cr_c), int'(cs_c), int'(bz_c), int'(ad_c), int'(cc_c));
            if (cs_a) starts_a++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_init(input int k, input int w);
        init_v[k] = 1'b1;
        repeat (w) cyc();
        init_v[k] = 1'b0;
    endtask

    // Load, then exactly n halt-free RUN edges, then halt; ends one cycle after HALTED.
    task automatic run_prog(input int k, input int w, input int n);
        pulse_init(k, w);
        cyc();
        repeat (n) cyc();
        halt_v[k] = 1'b1;
        cyc();
        halt_v[k] = 1'b0;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            init_v[i] = 1'b0;
            halt_v[i] = 1'b0;
        end
        m[0] = '0;
        m[1] = '0;
        m[2] = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset ProgState", int'(ps_a), 0);
        chk("reset core_reset", int'(cr_a), 0);
        chk("reset cycle_count", int'(cc_a), 0);

        // Three programs, no wrap.
        for (int p = 1; p <= 3; p++) begin
            run_prog(0, 2, 10);
            chk("seq ProgState", int'(ps_a), p);
            chk("seq cycle_count", int'(cc_a), 10);
            chk("seq busy", int'(bz_a), 0);
        end
        chk("seq all_done", int'(ad_a), 1);
        chk("seq starts", starts_a, 3);
        pulse_init(0, 2);
        repeat (3) cyc();
        chk("4th init ProgState", int'(ps_a), 3);
        chk("4th init starts", starts_a, 3);
        chk("4th init all_done", int'(ad_a), 1);

        // Wrap with two programs.
        for (int r = 0; r < 3; r++) begin
            run_prog(1, int'($urandom_range(1, 3)), int'($urandom_range(2, 12)));
            chk("wrap ProgState", int'(ps_b), (r == 1) ? 2 : 1);
            chk("wrap all_done", int'(ad_b), 0);
        end

        // Abort five cycles into a run.
        pulse_init(2, 1);
        cyc();
        repeat (5) cyc();
        chk("abort pre cycle_count", int'(cc_c), 5);
        init_v[2] = 1'b1;
        cyc();
        chk("abort core_reset", int'(cr_c), 1);
        chk("abort busy", int'(bz_c), 0);
        chk("abort ProgState", int'(ps_c), 1);
        init_v[2] = 1'b0;
        cyc();
        chk("abort reload ProgState", int'(ps_c), 2);
        chk("abort reload cycle_count", int'(cc_c), 0);
        chk("abort reload core_start", int'(cs_c), 1);

        // Saturation of the 4-bit counter.
        repeat (20) cyc();
        chk("sat cycle_count", int'(cc_c), 15);
        halt_v[2] = 1'b1;
        cyc();
        halt_v[2] = 1'b0;
        chk("sat busy", int'(bz_c), 0);
        chk("sat frozen", int'(cc_c), 15);

        // rise together with halt in RUN: reload wins.
        pulse_init(1, 1);
        cyc();
        repeat (3) cyc();
        init_v[1] = 1'b1;
        halt_v[1] = 1'b1;
        cyc();
        chk("simul core_reset", int'(cr_b), 1);
        chk("simul busy", int'(bz_b), 0);
        init_v[1] = 1'b0;
        halt_v[1] = 1'b0;
        cyc();
        chk("simul ProgState", int'(ps_b), 1);
        chk("simul core_start", int'(cs_b), 1);
        halt_v[1] = 1'b1;
        cyc();
        halt_v[1] = 1'b0;

        // Asynchronous reset mid-cycle, well away from the next rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset ProgState a", int'(ps_a), 0);
        chk("areset all_done a", int'(ad_a), 0);
        chk("areset ProgState b", int'(ps_b), 0);
        chk("areset cycle_count c", int'(cc_c), 0);
        chk("areset busy c", int'(bz_c), 0);
        cyc();
        rst_n = 1'b1;

        // halt held high in IDLE has no effect.
        for (int i = 0; i < 3; i++) halt_v[i] = 1'b1;
        repeat (5) cyc();
        chk("idle halt core_reset", int'(cr_a), 0);
        chk("idle halt busy", int'(bz_b), 0);
        chk("idle halt ProgState", int'(ps_c), 0);
        for (int i = 0; i < 3; i++) halt_v[i] = 1'b0;

        // Random traffic with periodic mid-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) init_v[i] = ~init_v[i];
                halt_v[i] = ($urandom_range(0, 7) == 0);
            end
            if (c % 600 == 599) begin
                #2;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
